// File: rtl/odo_sbox_pkg.sv
// Shared types and helpers for the Odo substitution-box lanes.
package odo_sbox_pkg;
  typedef enum logic [1:0] {LD_IDLE, LD_LOADING, LD_FULL} ld_state_t;

  localparam int SBOX_WIDTH = 6;
  localparam int SBOX_LANES = 4;

  function automatic int depth_of(input int width);
    return 1 << width;
  endfunction

  // LSB position of a lane inside a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/odo_sbox_bank.sv
// One sbox table: single write port, LANES registered read ports.
// Read registers only update on rd_en so a held result survives later writes.
module odo_sbox_bank
  import odo_sbox_pkg::*;
#(
  parameter int WIDTH = SBOX_WIDTH,
  parameter int LANES = SBOX_LANES
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic [LANES*WIDTH-1:0] rd_addr,
  output logic [LANES*WIDTH-1:0] rd_data
);
  localparam int DEPTH = depth_of(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int k = 0; k < LANES; k++) begin
        rd_data[lane_lsb(k, WIDTH) +: WIDTH] <= mem[rd_addr[lane_lsb(k, WIDTH) +: WIDTH]];
      end
    end
  end
endmodule

// File: rtl/odo_sbox_lanes.sv
// Multi-lane double-buffered sbox: 1-cycle lookups on the active bank while
// the shadow bank is loaded serially and swapped in atomically.
module odo_sbox_lanes
  import odo_sbox_pkg::*;
#(
  parameter int WIDTH = SBOX_WIDTH,
  parameter int LANES = SBOX_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   ld_ready,
  input  logic                   swap_req,
  output logic                   shadow_full,
  output logic                   bank_sel,
  output logic                   table_valid
);
  ld_state_t        state, state_nxt;
  logic [WIDTH-1:0] ld_cnt, ld_cnt_nxt;
  logic             bank_sel_nxt, table_valid_nxt, ld_we;

  always_comb begin
    state_nxt       = state;
    ld_cnt_nxt      = ld_cnt;
    bank_sel_nxt    = bank_sel;
    table_valid_nxt = table_valid;
    ld_we           = 1'b0;
    case (state)
      LD_IDLE: begin
        if (ld_start) begin
          state_nxt  = LD_LOADING;
          ld_cnt_nxt = '0;
        end
      end
      LD_LOADING: begin
        if (ld_start) begin
          ld_cnt_nxt = '0;
        end else if (ld_valid) begin
          ld_we      = 1'b1;
          ld_cnt_nxt = ld_cnt + 1'b1;
          // Full on the write of the last entry, not on the wrap to zero.
          if (&ld_cnt) state_nxt = LD_FULL;
        end
      end
      LD_FULL: begin
        if (ld_start) begin
          state_nxt  = LD_LOADING;
          ld_cnt_nxt = '0;
        end else if (swap_req) begin
          bank_sel_nxt    = ~bank_sel;
          table_valid_nxt = 1'b1;
          state_nxt       = LD_IDLE;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LD_IDLE;
      ld_cnt      <= '0;
      bank_sel    <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_cnt      <= ld_cnt_nxt;
      bank_sel    <= bank_sel_nxt;
      table_valid <= table_valid_nxt;
    end
  end

  assign ld_ready    = (state == LD_LOADING);
  assign shadow_full = (state == LD_FULL);

  logic accept, sel_q, tv_q;
  logic [LANES*WIDTH-1:0] rd0, rd1;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Bank choice and table validity are frozen at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sel_q     <= 1'b0;
      tv_q      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sel_q     <= bank_sel;
      tv_q      <= table_valid;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  odo_sbox_bank #(.WIDTH(WIDTH), .LANES(LANES)) u_bank0 (
    .clk     (clk),
    .wr_en   (ld_we && bank_sel),
    .wr_addr (ld_cnt),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_addr (in_data),
    .rd_data (rd0)
  );

  odo_sbox_bank #(.WIDTH(WIDTH), .LANES(LANES)) u_bank1 (
    .clk     (clk),
    .wr_en   (ld_we && !bank_sel),
    .wr_addr (ld_cnt),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_addr (in_data),
    .rd_data (rd1)
  );

  assign out_data = !tv_q ? '0 : (sel_q ? rd1 : rd0);
endmodule

// File: tb/tb_odo_sbox_lanes.sv
// Directed bench for odo_sbox_lanes with a table-level reference model.
module tb_odo_sbox_lanes;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 6-bit, 4-lane instance
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [23:0] in_data = '0, out_data;
  logic        ld_start = 0, ld_valid = 0, ld_ready, swap_req = 0;
  logic [5:0]  ld_data = '0;
  logic        shadow_full, bank_sel, table_valid;

  // 10-bit, 2-lane instance
  logic        in_valid10 = 0, in_ready10, out_valid10, out_ready10 = 1;
  logic [19:0] in_data10 = '0, out_data10;
  logic        ld_start10 = 0, ld_valid10 = 0, ld_ready10, swap_req10 = 0;
  logic [9:0]  ld_data10 = '0;
  logic        shadow_full10, bank_sel10, table_valid10;

  odo_sbox_lanes #(.WIDTH(6), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .swap_req(swap_req), .shadow_full(shadow_full), .bank_sel(bank_sel),
    .table_valid(table_valid)
  );

  odo_sbox_lanes #(.WIDTH(10), .LANES(2)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10),
    .ld_start(ld_start10), .ld_valid(ld_valid10), .ld_data(ld_data10), .ld_ready(ld_ready10),
    .swap_req(swap_req10), .shadow_full(shadow_full10), .bank_sel(bank_sel10),
    .table_valid(table_valid10)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: active/shadow tables as plain arrays, load progress as a write count.
  logic [5:0]  m_act [64];
  logic [5:0]  m_shd [64];
  int          m_nwr;
  bit          m_loading, m_full, m_sel, m_tv, m_ovld;
  logic [23:0] m_odat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ovld = 0; m_odat = '0; m_sel = 0; m_tv = 0;
      m_loading = 0; m_full = 0; m_nwr = 0;
    end else begin
      if (in_valid && (!m_ovld || out_ready)) begin
        m_ovld = 1;
        for (int k = 0; k < 4; k++)
          m_odat[k*6 +: 6] = m_tv ? m_act[int'(in_data[k*6 +: 6])] : 6'd0;
      end else if (out_ready) begin
        m_ovld = 0;
      end
      if (ld_start && (m_loading || m_full || (!m_loading && !m_full))) begin
        m_loading = 1; m_full = 0; m_nwr = 0;
      end else if (m_loading && ld_valid) begin
        m_shd[m_nwr] = ld_data;
        m_nwr++;
        if (m_nwr == 64) begin m_loading = 0; m_full = 1; end
      end else if (m_full && swap_req) begin
        for (int i = 0; i < 64; i++) m_act[i] = m_shd[i];
        m_sel = !m_sel; m_tv = 1; m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_out_valid", out_valid, m_ovld);
      if (m_ovld) chk("m_out_data", out_data, m_odat);
      chk("m_in_ready", in_ready, !m_ovld || out_ready);
      chk("m_bank_sel", bank_sel, m_sel);
      chk("m_table_valid", table_valid, m_tv);
      chk("m_shadow_full", shadow_full, m_full);
      chk("m_ld_ready", ld_ready, m_loading);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load6(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1;
      ld_data  = (mode == 0) ? 6'(i ^ 'h15) : 6'(63 - i);
      cyc();
    end
    ld_valid = 0;
  endtask

  initial begin
    #2 rst = 1;
    repeat (3) cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_table_valid", table_valid, 0);
    chk("rst_shadow_full", shadow_full, 0);
    chk("rst_ld_ready", ld_ready, 0);

    // Lookup before any table exists returns zeros.
    in_valid = 1; in_data = {4{6'h3F}};
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("pre_out_valid", out_valid, 1);
    chk("pre_out_data", out_data, 0);
    chk("pre_table_valid", table_valid, 0);
    cyc();

    // Load T[i]=i^0x15 and swap.
    ld_start = 1; cyc(); ld_start = 0;
    load6(0, 64);
    @(negedge clk);
    chk("full_after_64", shadow_full, 1);
    swap_req = 1; cyc(); swap_req = 0;
    @(negedge clk);
    chk("swap1_bank_sel", bank_sel, 1);
    chk("swap1_table_valid", table_valid, 1);

    in_valid = 1; in_data = {6'h3F, 6'h2A, 6'h01, 6'h00};
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("lookup_T", out_data, {6'h2A, 6'h3F, 6'h14, 6'h15});
    cyc();

    // Backpressure: result held for 3 cycles, next request waits.
    out_ready = 0; in_valid = 1; in_data = {4{6'h01}};
    cyc(); in_data = {4{6'h2A}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, {4{6'h14}});
      chk("bp_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1; #1;
    chk("bp_release_in_ready", in_ready, 1);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("bp_next_data", out_data, {4{6'h3F}});
    cyc();

    // Load T'[i]=63-i; lookups in the swap cycle and the one after.
    ld_start = 1; cyc(); ld_start = 0;
    load6(1, 64);
    swap_req = 1; in_valid = 1; in_data = {4{6'h05}};
    cyc(); swap_req = 0;
    @(negedge clk);
    chk("swap_cycle_old_bank", out_data, {4{6'h10}});
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("after_swap_new_bank", out_data, {4{6'h3A}});
    chk("swap2_bank_sel", bank_sel, 0);
    cyc();

    // swap_req while loading is ignored; ld_start beats ld_valid.
    ld_start = 1; cyc(); ld_start = 0;
    load6(0, 10);
    swap_req = 1; cyc(); swap_req = 0;
    @(negedge clk);
    chk("swap_in_loading_sel", bank_sel, 0);
    chk("swap_in_loading_ldrdy", ld_ready, 1);
    ld_start = 1; ld_valid = 1; ld_data = 6'h3F;
    cyc(); ld_start = 0; ld_valid = 0;
    load6(0, 63);
    @(negedge clk);
    chk("not_full_at_63", shadow_full, 0);
    ld_valid = 1; ld_data = 6'(63 ^ 'h15);
    cyc(); ld_valid = 0;
    @(negedge clk);
    chk("full_at_64", shadow_full, 1);
    swap_req = 1; cyc(); swap_req = 0;
    in_valid = 1; in_data = {6'h02, 6'h01, 6'h3F, 6'h00};
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("restart_lookup", out_data, {6'h17, 6'h14, 6'h2A, 6'h15});
    chk("restart_bank_sel", bank_sel, 1);
    cyc();

    // Reset in the middle of a load with a held result.
    out_ready = 0; in_valid = 1; in_data = '0;
    cyc(); in_valid = 0;
    ld_start = 1; cyc(); ld_start = 0;
    load6(1, 30);
    rst = 1; #1;
    chk("midrst_shadow_full", shadow_full, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_table_valid", table_valid, 0);
    chk("midrst_bank_sel", bank_sel, 0);
    cyc(); cyc();
    rst = 0; out_ready = 1;
    cyc();

    // Large sbox: identity load on the 10-bit instance.
    ld_start10 = 1; cyc(); ld_start10 = 0;
    for (int i = 0; i < 1024; i++) begin
      ld_valid10 = 1; ld_data10 = 10'(i);
      cyc();
    end
    ld_valid10 = 0;
    @(negedge clk);
    chk("w10_full", shadow_full10, 1);
    swap_req10 = 1; cyc(); swap_req10 = 0;
    in_valid10 = 1; in_data10 = {10'h155, 10'h3FF};
    cyc(); in_valid10 = 0;
    @(negedge clk);
    chk("w10_out_valid", out_valid10, 1);
    chk("w10_lookup", out_data10, {10'h155, 10'h3FF});
    chk("w10_table_valid", table_valid10, 1);
    chk("w10_bank_sel", bank_sel10, 1);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
